// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the product
// accumulator and the downstream result consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 16
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_overflow;
  logic [7:0]       out_index;

  // Producer/consumer side: drives products, clear and result acceptance.
  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, out_index
  );

  // Accumulator side.
  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_index
  );
endinterface

// File: rtl/product_accumulator.sv
// Streaming accumulator: sums LEN unsigned 8-bit products into one ACC_W-bit
// result with a sticky per-result carry flag, presented on a one-deep
// registered valid/ready output. Result boundaries cost no bubble when the
// consumer is ready.
module product_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [7:0]       cnt, cnt_next;
  logic             ovf, ovf_next;
  logic [7:0]       idx_cnt, idx_next;
  logic [ACC_W:0]   sum_p0;
  logic             accept, xfer, last, load;
  logic             vld_p1, vld_next;
  logic [ACC_W-1:0] sum_p1;
  logic             ovf_p1;
  logic [7:0]       idx_p1;

  // Unsigned add that keeps the carry-out in the top bit.
  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                               input logic [7:0] b);
    return {1'b0, a} + {{(ACC_W - 7){1'b0}}, b};
  endfunction

  assign bus.in_ready = rst_n && !bus.clear && (state == ACCUM || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = vld_p1 && bus.out_ready;
  assign last         = accept && (cnt == LAST_CNT);

  // ---- stage p0: accumulate the accepted product combinationally ----
  // acc is zero whenever the FSM is in HOLD, so the same adder also forms
  // the first term of the next result on a same-cycle transfer+accept.
  assign sum_p0 = add_carry(acc, bus.in_product);

  // Next-state, accumulator and output-load decisions.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    idx_next   = idx_cnt;
    vld_next   = vld_p1;
    load       = 1'b0;
    case (state)
      ACCUM: ;
      HOLD: begin
        if (xfer) begin
          vld_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
    if (accept) begin
      if (last) begin
        load       = 1'b1;
        vld_next   = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
        ovf_next   = 1'b0;
        idx_next   = idx_cnt + 8'd1;
        state_next = HOLD;
      end else begin
        acc_next = sum_p0[ACC_W-1:0];
        ovf_next = ovf | sum_p0[ACC_W];
        cnt_next = cnt + 8'd1;
      end
    end
    if (bus.clear) begin
      acc_next = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // ---- stage p1: partial-sum state and the registered result ----
  // Result registers are reset too so a fresh block presents zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      idx_cnt <= '0;
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      ovf_p1  <= 1'b0;
      idx_p1  <= '0;
    end else begin
      acc     <= acc_next;
      cnt     <= cnt_next;
      ovf     <= ovf_next;
      idx_cnt <= idx_next;
      vld_p1  <= vld_next;
      if (load) begin
        sum_p1 <= sum_p0[ACC_W-1:0];
        ovf_p1 <= ovf | sum_p0[ACC_W];
        idx_p1 <= idx_cnt;
      end
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_sum      = sum_p1;
  assign bus.out_overflow = ovf_p1;
  assign bus.out_index    = idx_p1;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (LEN4/16b, LEN8/10b,
// LEN1/16b) driven one at a time; a behavioural model pushes expected results
// into a scoreboard queue that each scenario pops when a result appears.
module tb_product_accumulator;
  localparam int LEN_T [3] = '{4, 8, 1};
  localparam int WID_T [3] = '{16, 10, 16};

  typedef struct { int sum; bit ovf; int idx; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        tv   [3];
  logic        tclr [3];
  logic        tordy[3];
  logic [7:0]  tp   [3];
  logic        trdy [3];
  logic        tov  [3];
  logic        tovf [3];
  logic [31:0] tsum [3];
  logic [7:0]  tidx [3];

  product_accumulator_if #(.ACC_W(16)) if4 ();
  product_accumulator_if #(.ACC_W(10)) if8 ();
  product_accumulator_if #(.ACC_W(16)) if1 ();

  product_accumulator #(.LEN(4), .ACC_W(16)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  product_accumulator #(.LEN(8), .ACC_W(10)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  product_accumulator #(.LEN(1), .ACC_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if4.in_valid = tv[0]; assign if4.in_product = tp[0]; assign if4.out_ready = tordy[0]; assign if4.clear = tclr[0];
  assign if8.in_valid = tv[1]; assign if8.in_product = tp[1]; assign if8.out_ready = tordy[1]; assign if8.clear = tclr[1];
  assign if1.in_valid = tv[2]; assign if1.in_product = tp[2]; assign if1.out_ready = tordy[2]; assign if1.clear = tclr[2];
  assign trdy[0] = if4.in_ready; assign tov[0] = if4.out_valid; assign tovf[0] = if4.out_overflow;
  assign trdy[1] = if8.in_ready; assign tov[1] = if8.out_valid; assign tovf[1] = if8.out_overflow;
  assign trdy[2] = if1.in_ready; assign tov[2] = if1.out_valid; assign tovf[2] = if1.out_overflow;
  assign tsum[0] = {16'd0, if4.out_sum}; assign tidx[0] = if4.out_index;
  assign tsum[1] = {22'd0, if8.out_sum}; assign tidx[1] = if8.out_index;
  assign tsum[2] = {16'd0, if1.out_sum}; assign tidx[2] = if1.out_index;

  exp_t sb[$];
  int   m_acc[3], m_cnt[3], m_idx[3];
  bit   m_ovf[3];
  int   n_pass = 0, n_total = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_idx[i] = 0; m_ovf[i] = 0;
    end
    sb.delete();
  endtask

  // One clock cycle on instance k, entered and left at a falling edge.
  // Updates the model on accepts/clears; nr flags a newly presented result.
  task automatic step(input int k, input logic v, input logic [7:0] p, input logic ordy,
                      input logic clr, output logic rdy, output logic accd, output logic nr);
    logic pv, xf;
    int   full;
    tv[k] = v; tp[k] = p; tordy[k] = ordy; tclr[k] = clr;
    #1;
    rdy  = trdy[k];
    accd = v && rdy;
    pv   = tov[k];
    xf   = pv && ordy;
    if (accd) begin
      full = m_acc[k] + int'(p);
      if (full >= (1 << WID_T[k])) begin
        m_ovf[k] = 1'b1;
        full -= (1 << WID_T[k]);
      end
      m_acc[k] = full;
      m_cnt[k]++;
      if (m_cnt[k] == LEN_T[k]) begin
        sb.push_back('{sum: m_acc[k], ovf: m_ovf[k], idx: m_idx[k]});
        m_idx[k] = (m_idx[k] + 1) % 256;
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
      end
    end else if (clr) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
    @(negedge clk);
    nr = tov[k] && (!pv || xf);
    tv[k] = 1'b0; tclr[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic r, a, nr;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b0; tp[i] = '0; tordy[i] = 1'b1; tclr[i] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    step(0, 1'b1, 8'd9, 1'b1, 1'b0, r, a, nr);
    n_total++; if (r !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", r); else n_pass++;
    n_total++; if (tov[0] !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", tov[0]); else n_pass++;
    n_total++; if (tsum[0] !== 32'd0) $display("FAIL reset_out_sum got %0d want 0", tsum[0]); else n_pass++;
    n_total++; if (tovf[0] !== 1'b0 || tidx[0] !== 8'd0) $display("FAIL reset_ovf_idx got %0b/%0d want 0/0", tovf[0], tidx[0]); else n_pass++;
    n_total++; if (tov[1] !== 1'b0 || tov[2] !== 1'b0) $display("FAIL reset_other_valid got %0b/%0b want 0/0", tov[1], tov[2]); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic r, a, nr;
    exp_t e;
    int   got = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 8'd225, 1'b1, 1'b0, r, a, nr);
      n_total++; if (r !== 1'b1) $display("FAIL basic_in_ready beat %0d got %0b want 1", i, r); else n_pass++;
      if (nr) begin
        got++;
        n_total++;
        if (sb.size() == 0) $display("FAIL basic_result unexpected sum=%0d", tsum[0]);
        else begin
          e = sb.pop_front();
          if (tsum[0] !== e.sum || tovf[0] !== e.ovf || tidx[0] !== e.idx)
            $display("FAIL basic_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[0], tovf[0], tidx[0], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
      end
    end
    n_total++; if (got !== 1 || tsum[0] !== 32'd900 || tidx[0] !== 8'd0) $display("FAIL basic_latency got n=%0d sum=%0d idx=%0d want 1/900/0", got, tsum[0], tidx[0]); else n_pass++;
    step(0, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
    n_total++; if (tov[0] !== 1'b0) $display("FAIL basic_drain got %0b want 0", tov[0]); else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic r, a, nr;
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      // beats 0-3: first result; 4-6: stalled in HOLD; 7-10: second result
      step(0, 1'b1, 8'd225, (i >= 7), 1'b0, r, a, nr);
      if (i >= 4 && i <= 6) begin
        n_total++; if (r !== 1'b0 || tsum[0] !== 32'd900 || tov[0] !== 1'b1) $display("FAIL bp_hold got rdy=%0b sum=%0d vld=%0b want 0/900/1", r, tsum[0], tov[0]); else n_pass++;
      end
      if (i == 7) begin
        n_total++; if (a !== 1'b1 || tov[0] !== 1'b0) $display("FAIL bp_release got acc=%0b vld=%0b want 1/0", a, tov[0]); else n_pass++;
      end
      if (nr) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL bp_result unexpected sum=%0d", tsum[0]);
        else begin
          e = sb.pop_front();
          if (tsum[0] !== e.sum || tovf[0] !== e.ovf || tidx[0] !== e.idx)
            $display("FAIL bp_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[0], tovf[0], tidx[0], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
      end
    end
    n_total++; if (tsum[0] !== 32'd900 || tidx[0] !== 8'd2) $display("FAIL bp_second got %0d/%0d want 900/2", tsum[0], tidx[0]); else n_pass++;
    step(0, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
  endtask

  task automatic test_overflow();
    logic r, a, nr;
    exp_t e;
    int   nres = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1'b1, (i < 8) ? 8'd225 : 8'd1, 1'b1, 1'b0, r, a, nr);
      n_total++; if (a !== 1'b1) $display("FAIL ovf_accept beat %0d got %0b want 1", i, a); else n_pass++;
      if (nr) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL ovf_result unexpected sum=%0d", tsum[1]);
        else begin
          e = sb.pop_front();
          if (tsum[1] !== e.sum || tovf[1] !== e.ovf || tidx[1] !== e.idx)
            $display("FAIL ovf_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[1], tovf[1], tidx[1], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
        n_total++;
        if (nres == 0 && (tsum[1] !== 32'd776 || tovf[1] !== 1'b1)) $display("FAIL ovf_wrap got %0d/%0b want 776/1", tsum[1], tovf[1]);
        else if (nres == 1 && (tsum[1] !== 32'd8 || tovf[1] !== 1'b0)) $display("FAIL ovf_sticky got %0d/%0b want 8/0", tsum[1], tovf[1]);
        else n_pass++;
        nres++;
      end
    end
    n_total++; if (nres !== 2) $display("FAIL ovf_count got %0d want 2", nres); else n_pass++;
    step(1, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
  endtask

  task automatic test_len1();
    logic [7:0] vals [3];
    logic r, a, nr;
    exp_t e;
    vals = '{8'd3, 8'd7, 8'd9};
    for (int i = 0; i < 3; i++) begin
      step(2, 1'b1, vals[i], 1'b1, 1'b0, r, a, nr);
      n_total++; if (nr !== 1'b1 || tov[2] !== 1'b1 || tsum[2] !== 32'(vals[i]) || tidx[2] !== 8'(i))
        $display("FAIL len1_stream beat %0d got nr=%0b vld=%0b sum=%0d idx=%0d want 1/1/%0d/%0d", i, nr, tov[2], tsum[2], tidx[2], vals[i], i);
      else n_pass++;
      if (nr) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL len1_result unexpected sum=%0d", tsum[2]);
        else begin
          e = sb.pop_front();
          if (tsum[2] !== e.sum || tovf[2] !== e.ovf || tidx[2] !== e.idx)
            $display("FAIL len1_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[2], tovf[2], tidx[2], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
      end
    end
    step(2, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
    n_total++; if (tov[2] !== 1'b0) $display("FAIL len1_drain got %0b want 0", tov[2]); else n_pass++;
  endtask

  task automatic test_clear();
    logic [7:0] vals [7];
    logic r, a, nr;
    exp_t e;
    vals = '{8'd10, 8'd20, 8'd99, 8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 7; i++) begin
      step(0, 1'b1, vals[i], 1'b1, (i == 2), r, a, nr);
      if (i == 2) begin
        n_total++; if (r !== 1'b0 || a !== 1'b0) $display("FAIL clear_in_ready got %0b want 0", r); else n_pass++;
      end
      if (nr) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL clear_result unexpected sum=%0d", tsum[0]);
        else begin
          e = sb.pop_front();
          if (tsum[0] !== e.sum || tovf[0] !== e.ovf || tidx[0] !== e.idx)
            $display("FAIL clear_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[0], tovf[0], tidx[0], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
      end
    end
    n_total++; if (tov[0] !== 1'b1 || tsum[0] !== 32'd10) $display("FAIL clear_sum got vld=%0b sum=%0d want 1/10", tov[0], tsum[0]); else n_pass++;
    step(0, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
  endtask

  task automatic test_reset_midstream();
    logic r, a, nr;
    exp_t e;
    step(0, 1'b1, 8'd5, 1'b1, 1'b0, r, a, nr);
    step(0, 1'b1, 8'd5, 1'b1, 1'b0, r, a, nr);
    rst_n = 1'b0;
    step(0, 1'b1, 8'd5, 1'b1, 1'b0, r, a, nr);
    n_total++; if (r !== 1'b0) $display("FAIL rstmid_in_ready got %0b want 0", r); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    n_total++; if (tov[0] !== 1'b0 || tidx[0] !== 8'd0) $display("FAIL rstmid_state got vld=%0b idx=%0d want 0/0", tov[0], tidx[0]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 8'd5, 1'b1, 1'b0, r, a, nr);
      if (nr) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL rstmid_result unexpected sum=%0d", tsum[0]);
        else begin
          e = sb.pop_front();
          if (tsum[0] !== e.sum || tovf[0] !== e.ovf || tidx[0] !== e.idx)
            $display("FAIL rstmid_result got %0d/%0b/%0d want %0d/%0b/%0d", tsum[0], tovf[0], tidx[0], e.sum, e.ovf, e.idx);
          else n_pass++;
        end
      end
    end
    n_total++; if (tov[0] !== 1'b1 || tsum[0] !== 32'd20 || tidx[0] !== 8'd0) $display("FAIL rstmid_sum got %0b/%0d/%0d want 1/20/0", tov[0], tsum[0], tidx[0]); else n_pass++;
    step(0, 1'b0, 8'd0, 1'b1, 1'b0, r, a, nr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_overflow();
    test_len1();
    test_clear();
    test_reset_midstream();
    n_total++; if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d pending want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
